// File: rtl/exe_stage_iter.sv
// ARM-style execute stage: registered single-cycle ALU, NZCV status register,
// branch-target adder, and an iterative shift-add multiplier (MUL/MLA).
module exe_stage_iter #(
  parameter int WIDTH = 32,
  parameter int IMM_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       exe_cmd,
  input  logic             s,
  input  logic [WIDTH-1:0] val1,
  input  logic [WIDTH-1:0] val2,
  input  logic [WIDTH-1:0] val_acc,
  input  logic [WIDTH-1:0] pc,
  input  logic [IMM_W-1:0] imm_signed,
  output logic             out_valid,
  output logic [WIDTH-1:0] alu_res,
  output logic [3:0]       status,
  output logic [WIDTH-1:0] branch_addr
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int OFF_W = (WIDTH > IMM_W + 2) ? WIDTH : IMM_W + 2;
  localparam int MSB   = WIDTH - 1;

  localparam logic [3:0] CMD_MOV = 4'b0001;
  localparam logic [3:0] CMD_MVN = 4'b1001;
  localparam logic [3:0] CMD_ADD = 4'b0010;
  localparam logic [3:0] CMD_ADC = 4'b0011;
  localparam logic [3:0] CMD_SUB = 4'b0100;
  localparam logic [3:0] CMD_SBC = 4'b0101;
  localparam logic [3:0] CMD_AND = 4'b0110;
  localparam logic [3:0] CMD_ORR = 4'b0111;
  localparam logic [3:0] CMD_EOR = 4'b1000;
  localparam logic [3:0] CMD_MUL = 4'b1010;
  localparam logic [3:0] CMD_MLA = 4'b1011;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               w_accept;
  logic               w_is_mul;
  logic [WIDTH-1:0]   w_b;
  logic               w_cin;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH-1:0]   w_res;
  logic               w_c;
  logic               w_v;
  logic [3:0]         w_status_alu;
  logic [OFF_W-1:0]   w_off_ext;

  logic [WIDTH-1:0]   r_alu_res;
  logic               r_out_valid;
  logic [3:0]         r_status;
  logic [WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [WIDTH-1:0]   r_acc;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_s;

  assign w_is_mul = (exe_cmd == CMD_MUL) || (exe_cmd == CMD_MLA);
  assign w_accept = in_valid & in_ready & ~flush;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_accept && w_is_mul) w_state_nxt = S_MUL;
      S_MUL: begin
        if (flush)               w_state_nxt = S_IDLE;
        else if (r_cnt == '0)    w_state_nxt = S_DONE;
      end
      S_DONE: w_state_nxt = (w_accept && w_is_mul) ? S_MUL : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready = (r_state != S_MUL);
  end

  // Subtraction is a + ~b + cin, so C comes out directly as NOT borrow.
  always_comb begin
    w_b   = val2;
    w_cin = 1'b0;
    case (exe_cmd)
      CMD_ADC: w_cin = r_status[1];
      CMD_SUB: begin w_b = ~val2; w_cin = 1'b1;        end
      CMD_SBC: begin w_b = ~val2; w_cin = r_status[1]; end
      default: ;
    endcase
  end

  assign w_sum = {1'b0, val1} + {1'b0, w_b} + (WIDTH + 1)'(w_cin);

  // NOTE: every variable driven here gets a default first so no latch is inferred.
  always_comb begin
    w_res = '0;
    w_c   = r_status[1];
    w_v   = r_status[0];
    case (exe_cmd)
      CMD_MOV: w_res = val2;
      CMD_MVN: w_res = ~val2;
      CMD_AND: w_res = val1 & val2;
      CMD_ORR: w_res = val1 | val2;
      CMD_EOR: w_res = val1 ^ val2;
      CMD_ADD, CMD_ADC, CMD_SUB, CMD_SBC: begin
        w_res = w_sum[MSB:0];
        w_c   = w_sum[WIDTH];
        w_v   = (val1[MSB] == w_b[MSB]) && (w_sum[MSB] != val1[MSB]);
      end
      default: w_res = '0;
    endcase
  end

  assign w_status_alu = {w_res[MSB], ~|w_res, w_c, w_v};

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_alu_res   <= '0;
      r_out_valid <= 1'b0;
      r_status    <= 4'b0000;
      r_mcand     <= '0;
      r_mplier    <= '0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_s         <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      if (w_accept) begin
        if (w_is_mul) begin
          r_mcand  <= val1;
          r_mplier <= val2;
          r_acc    <= (exe_cmd == CMD_MLA) ? val_acc : '0;
          r_cnt    <= CNT_W'(WIDTH);
          r_s      <= s;
        end else begin
          r_alu_res   <= w_res;
          r_out_valid <= 1'b1;
          if (s) r_status <= w_status_alu;
        end
      end else if (r_state == S_MUL && !flush) begin
        if (r_cnt == '0) begin
          r_alu_res   <= r_acc;
          r_out_valid <= 1'b1;
          if (r_s) r_status <= {r_acc[MSB], ~|r_acc, r_status[1:0]};
        end else begin
          if (r_mplier[0]) r_acc <= r_acc + r_mcand;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt - 1'b1;
        end
      end
    end
  end

  assign w_off_ext   = {{(OFF_W - IMM_W){imm_signed[IMM_W-1]}}, imm_signed};
  assign branch_addr = pc + WIDTH'({w_off_ext, 2'b00});

  assign alu_res   = r_alu_res;
  assign out_valid = r_out_valid;
  assign status    = r_status;

endmodule

// File: tb/tb_exe_stage_iter.sv
// Self-checking bench for exe_stage_iter: directed cases plus random ops
// compared against an arithmetic reference model of ARM ALU/multiply semantics.
module tb_exe_stage_iter;
  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    exe_cmd;
  logic          s;
  logic [W-1:0]  val1, val2, val_acc, pc;
  logic [23:0]   imm_signed;
  logic          out_valid;
  logic [W-1:0]  alu_res;
  logic [3:0]    status;
  logic [W-1:0]  branch_addr;

  int n_checks = 0;
  int n_pass   = 0;
  logic [3:0] m_status;

  exe_stage_iter #(.WIDTH(W), .IMM_W(24)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .exe_cmd(exe_cmd), .s(s), .val1(val1), .val2(val2), .val_acc(val_acc), .pc(pc),
    .imm_signed(imm_signed), .out_valid(out_valid), .alu_res(alu_res),
    .status(status), .branch_addr(branch_addr)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: ARM data-processing semantics from plain 64-bit arithmetic.
  function automatic void ref_alu(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                                  input logic sf, input logic [3:0] st,
                                  output logic [31:0] res, output logic [3:0] st_n);
    longint unsigned ua  = a;
    longint unsigned ub  = b;
    longint unsigned uc  = st[1];
    longint          sa  = longint'(signed'(a));
    longint          sb  = longint'(signed'(b));
    longint          sc  = longint'(uc);
    longint unsigned ur  = 0;
    longint          sr  = 0;
    logic [31:0]     r32;
    logic            cn  = st[1];
    logic            vn  = st[0];
    bit              arith = 0;
    res = '0;
    case (cmd)
      4'b0001: res = b;
      4'b1001: res = ~b;
      4'b0110: res = a & b;
      4'b0111: res = a | b;
      4'b1000: res = a ^ b;
      4'b0010: begin ur = ua + ub;      sr = sa + sb;      cn = ur[32]; arith = 1; end
      4'b0011: begin ur = ua + ub + uc; sr = sa + sb + sc; cn = ur[32]; arith = 1; end
      4'b0100: begin ur = ua - ub;      sr = sa - sb;      cn = (ua >= ub); arith = 1; end
      4'b0101: begin
        ur = ua - ub - (1 - uc);
        sr = sa - sb - (1 - sc);
        cn = (ua >= ub + (1 - uc));
        arith = 1;
      end
      default: res = '0;
    endcase
    if (arith) begin
      r32 = ur[31:0];
      res = r32;
      vn  = (sr != longint'(signed'(r32)));
    end
    st_n = sf ? {res[31], res == 32'd0, cn, vn} : st;
  endfunction

  task automatic issue_alu(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                           input logic sf, input string tag);
    logic [31:0] e_res;
    logic [3:0]  e_st;
    ref_alu(cmd, a, b, sf, m_status, e_res, e_st);
    exe_cmd = cmd; val1 = a; val2 = b; s = sf; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check({tag, ".valid"}, out_valid, 1'b1);
    check({tag, ".res"}, alu_res, e_res);
    check({tag, ".status"}, status, e_st);
    m_status = e_st;
  endtask

  // Leaves the bench in the DONE cycle (out_valid high) on return.
  task automatic issue_mul(input logic mla, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] acc, input logic sf, input string tag);
    longint unsigned prod = longint'(a) * longint'(b) + (mla ? longint'(acc) : 64'd0);
    logic [31:0] e_res = prod[31:0];
    logic [3:0]  e_st  = sf ? {e_res[31], e_res == 32'd0, m_status[1:0]} : m_status;
    int lat = 0;
    int busy_bad = 0;
    exe_cmd = mla ? 4'b1011 : 4'b1010;
    val1 = a; val2 = b; val_acc = acc; s = sf; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check({tag, ".ready0"}, in_ready, 1'b0);
    for (int n = 1; n <= W + 8; n++) begin
      tick();
      if (out_valid) begin lat = n; break; end
      if (in_ready !== 1'b0) busy_bad++;
    end
    check({tag, ".latency"}, lat, W + 1);
    check({tag, ".busy"}, busy_bad, 0);
    check({tag, ".res"}, alu_res, e_res);
    check({tag, ".status"}, status, e_st);
    check({tag, ".ready_done"}, in_ready, 1'b1);
    m_status = e_st;
  endtask

  initial begin
    logic [3:0]  cmds [14] = '{4'h1, 4'h9, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8,
                               4'hA, 4'hB, 4'h0, 4'hC, 4'hF};
    logic [31:0] corners [5] = '{32'h0, 32'h1, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};
    logic [31:0] ra, rb;
    logic [31:0] e_br;
    longint      off;
    int          cnt;

    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; exe_cmd = '0; s = 1'b0;
    val1 = '0; val2 = '0; val_acc = '0; pc = '0; imm_signed = '0;
    m_status = 4'b0000;
    #12;
    check("reset.out_valid", out_valid, 1'b0);
    check("reset.alu_res", alu_res, 32'd0);
    check("reset.status", status, 4'b0000);
    rst = 1'b1;
    tick();
    check("reset.in_ready", in_ready, 1'b1);

    issue_alu(4'b0010, 32'h7FFF_FFFF, 32'h1, 1'b1, "add_ovf");
    check("add_ovf.nzcv", status, 4'b1001);
    issue_alu(4'b0100, 32'd5, 32'd5, 1'b1, "sub_eq");
    check("sub_eq.nzcv", status, 4'b0110);
    issue_alu(4'b0011, 32'd1, 32'd1, 1'b1, "adc_c1");
    check("adc_c1.res3", alu_res, 32'd3);

    issue_mul(1'b0, 32'h0000_FFFF, 32'h0001_0001, 32'd0, 1'b1, "mul");
    check("mul.ffff", alu_res, 32'hFFFF_FFFF);
    tick();
    check("mul.single_pulse", out_valid, 1'b0);

    issue_mul(1'b1, 32'd3, 32'd4, 32'd5, 1'b0, "mla");
    check("mla.17", alu_res, 32'd17);
    issue_alu(4'b0010, 32'd100, 32'd23, 1'b0, "add_in_done");

    // flush coincident with DONE: the multiply result still lands, new op blocked
    issue_mul(1'b0, 32'd6, 32'd7, 32'd0, 1'b1, "mul_fd");
    flush = 1'b1; exe_cmd = 4'b0010; val1 = 32'd1; val2 = 32'd1; in_valid = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check("flush_done.no_accept", out_valid, 1'b0);
    check("flush_done.res_kept", alu_res, 32'd42);

    // flush mid-multiply at edge 10
    exe_cmd = 4'b1010; val1 = 32'd0; val2 = 32'd0; s = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (9) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_mul.ready", in_ready, 1'b1);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (out_valid) cnt++;
    end
    check("flush_mul.no_valid", cnt, 0);
    check("flush_mul.status", status, m_status);

    flush = 1'b1; exe_cmd = 4'b0100; val1 = 32'd3; val2 = 32'd3; s = 1'b1; in_valid = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check("flush_idle.no_accept", out_valid, 1'b0);
    check("flush_idle.status", status, m_status);

    // reset in the middle of a multiply
    issue_alu(4'b0100, 32'd5, 32'd5, 1'b1, "pre_rst_sub");
    issue_alu(4'b0010, 32'd1, 32'd2, 1'b0, "pre_rst_add");
    exe_cmd = 4'b1010; val1 = 32'hABCD; val2 = 32'h1234; s = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (15) tick();
    rst = 1'b0;
    #1;
    check("rst_mul.out_valid", out_valid, 1'b0);
    check("rst_mul.alu_res", alu_res, 32'd0);
    check("rst_mul.status", status, 4'b0000);
    #2 rst = 1'b1;
    m_status = 4'b0000;
    tick();
    check("rst_mul.ready", in_ready, 1'b1);
    check("rst_mul.no_valid", out_valid, 1'b0);
    issue_alu(4'b0010, 32'hFFFF_FFFF, 32'd1, 1'b1, "post_rst_add");

    pc = 32'h100; imm_signed = 24'hFFFFFF;
    #1 check("branch.neg", branch_addr, 32'h0000_00FC);
    imm_signed = 24'h000004;
    #1 check("branch.pos", branch_addr, 32'h0000_0110);
    for (int i = 0; i < 6; i++) begin
      pc = $urandom; imm_signed = 24'($urandom);
      off  = longint'(signed'(imm_signed));
      e_br = 32'(longint'(pc) + off * 4);
      #1 check($sformatf("branch.rand%0d", i), branch_addr, e_br);
    end

    for (int i = 0; i < 60; i++) begin
      logic [3:0] c = cmds[$urandom_range(0, 13)];
      ra = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : 32'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : 32'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        tick();
        check($sformatf("rand%0d.idle", i), out_valid, 1'b0);
      end
      if (c == 4'hA || c == 4'hB)
        issue_mul(c[0], ra, rb, 32'($urandom), 1'($urandom), $sformatf("rand%0d.mul", i));
      else
        issue_alu(c, ra, rb, 1'($urandom), $sformatf("rand%0d.alu", i));
    end

    tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
